// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Optional line-break feature enabled by defining UART_TX_BREAK_EN (adds input break_i).
module uart_tx #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_stop_bits_i,
    input  logic [7:0]           tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_i,
`endif
    output logic                 tx_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [1:0]           bits_q, bits_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 brk;
    logic                 bit_done;
    logic [7:0]           data_mask;
    logic [7:0]           masked_data;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    assign bit_done    = (baud_q == div_q);
    assign data_mask   = 8'hFF >> (2'd3 - cfg_bits_i);
    assign masked_data = tx_data_i & data_mask;

    assign tx_ready_o = cfg_en_i & (state_q == S_IDLE) & ~brk;
    assign busy_o     = (state_q != S_IDLE);
    assign tx_o       = tx_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        par_d    = par_q;
        tx_d     = tx_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        // tx_d always carries the level for the state being entered, so tx_o is registered.
        case (state_q)
            S_IDLE: begin
                tx_d = ~(cfg_en_i & brk);
                if (tx_ready_o && tx_valid_i) begin
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
                    shift_d  = masked_data;
                    par_d    = ^masked_data;
                    div_d    = cfg_div_i;
                    bits_d   = cfg_bits_i;
                    par_en_d = cfg_parity_en_i;
                    stop2_d  = cfg_stop_bits_i;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == (3'(bits_q) + 3'd4)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        tx_d    = par_en_q ? par_q : 1'b1;
                        bit_d   = '0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                        shift_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Disabling drops any partial frame on the next edge.
        if (!cfg_en_i) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            bits_q   <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            bits_q   <= bits_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and randomized frames against a line-level model.
module tb_uart_tx;

    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cfg_en_i;
    logic [DW-1:0] cfg_div_i;
    logic          cfg_parity_en_i;
    logic [1:0]    cfg_bits_i;
    logic          cfg_stop_bits_i;
    logic [7:0]    tx_data_i;
    logic          tx_valid_i;
    logic          tx_ready_o;
    logic          tx_o;
    logic          busy_o;
`ifdef UART_TX_BREAK_EN
    logic          break_i;
`endif

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    uart_tx #(.DIV_WIDTH(DW)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_bits_i      (cfg_bits_i),
        .cfg_stop_bits_i (cfg_stop_bits_i),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
`ifdef UART_TX_BREAK_EN
        .break_i         (break_i),
`endif
        .tx_o            (tx_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    task automatic build_frame(input logic [7:0] d, input int bits, input bit par, input bit stop2);
        int n;
        int ones;
        n    = bits + 5;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par) exp_q.push_back(bit'(ones % 2));
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
    endtask

    // Called at a negedge with ready high and valid high: the next posedge is the transfer.
    task automatic check_frame(input logic [7:0] d, input int bits, input bit par, input bit stop2,
                               input int div, input bit keep_valid, input bit perturb);
        int len;
        int nerr;
        nerr = 0;
        build_frame(d, bits, par, stop2);
        len = exp_q.size() * (div + 1);
        @(posedge clk_i);
        #1;
        if (!keep_valid) tx_valid_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk_i);
            if (tx_o !== exp_q[i / (div + 1)] || busy_o !== 1'b1 || tx_ready_o !== 1'b0) nerr++;
            if (perturb && i == len / 2) begin
                cfg_div_i       = cfg_div_i + 16'd5;
                cfg_bits_i      = ~cfg_bits_i;
                cfg_parity_en_i = ~cfg_parity_en_i;
                cfg_stop_bits_i = ~cfg_stop_bits_i;
            end
        end
        check("frame_wave", 32'(nerr), 32'd0);
        @(negedge clk_i);
        check("frame_end", 32'({tx_o, busy_o, tx_ready_o}), 32'b101);
    endtask

    task automatic send(input logic [7:0] d, input int bits, input bit par, input bit stop2, input int div);
        cfg_div_i       = DW'(div);
        cfg_bits_i      = 2'(bits);
        cfg_parity_en_i = par;
        cfg_stop_bits_i = stop2;
        tx_data_i       = d;
        tx_valid_i      = 1'b1;
        check_frame(d, bits, par, stop2, div, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        int nerr;
        rst_n_i         = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_div_i       = '0;
        cfg_parity_en_i = 1'b0;
        cfg_bits_i      = 2'd3;
        cfg_stop_bits_i = 1'b0;
        tx_data_i       = '0;
        tx_valid_i      = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_i         = 1'b0;
`endif
        #12;
        check("reset", 32'({tx_o, busy_o, tx_ready_o}), 32'b100);
        @(negedge clk_i);
        rst_n_i  = 1'b1;
        cfg_en_i = 1'b1;
        @(negedge clk_i);
        check("idle_after_reset", 32'({tx_o, busy_o, tx_ready_o}), 32'b101);

        // 8 bits, no parity, 1 stop, div=3
        send(8'hA5, 3, 1'b0, 1'b0, 3);
        // 5 bits with ignored upper bits, parity, 2 stop
        send(8'hFB, 0, 1'b1, 1'b1, 2);
        // div=0 boundary
        send(8'h3C, 3, 1'b1, 1'b1, 0);

        for (int k = 0; k < 150; k++) begin
            send(8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Valid held high across three back-to-back characters
        cfg_div_i = 16'd1; cfg_bits_i = 2'd2; cfg_parity_en_i = 1'b1; cfg_stop_bits_i = 1'b0;
        tx_data_i = 8'h5A; tx_valid_i = 1'b1;
        check_frame(8'h5A, 2, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        tx_data_i = 8'hC3;
        check_frame(8'hC3, 2, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        tx_data_i = 8'h0F;
        check_frame(8'h0F, 2, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        nerr = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0 || tx_o !== 1'b1) nerr++;
        end
        check("b2b_no_fourth", 32'(nerr), 32'd0);

        // Disable during DATA bit 3
        d = 8'($urandom);
        cfg_div_i = 16'd2; cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        tx_data_i = d; tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
        repeat (14) @(negedge clk_i);
        check("data_bit3", 32'(tx_o), 32'(d[3]));
        cfg_en_i = 1'b0;
        @(negedge clk_i);
        check("disable", 32'({tx_o, busy_o, tx_ready_o}), 32'b100);
        tx_valid_i = 1'b1;
        nerr = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0 || tx_ready_o !== 1'b0 || tx_o !== 1'b1) nerr++;
        end
        check("disabled_no_accept", 32'(nerr), 32'd0);
        cfg_en_i = 1'b1;
        send(8'h55, 3, 1'b0, 1'b0, 2);

        // Config change mid-frame, then the next frame uses the new values
        cfg_div_i = 16'd3; cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        tx_data_i = 8'h96; tx_valid_i = 1'b1;
        check_frame(8'h96, 3, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        d = 8'($urandom);
        tx_data_i = d; tx_valid_i = 1'b1;
        check_frame(d, 0, 1'b1, 1'b1, 8, 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        cfg_div_i = 16'd2; cfg_bits_i = 2'd3; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
        tx_data_i = 8'h00; tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
        repeat (7) @(negedge clk_i);
        check("pre_reset_low", 32'(tx_o), 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_reset", 32'({tx_o, busy_o}), 32'b10);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        send(8'hE7, 1, 1'b1, 1'b0, 1);

`ifdef UART_TX_BREAK_EN
        break_i = 1'b1;
        check("break_ready", 32'(tx_ready_o), 32'd0);
        nerr = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (tx_o !== 1'b0 || tx_ready_o !== 1'b0 || busy_o !== 1'b0) nerr++;
        end
        check("break_hold", 32'(nerr), 32'd0);
        break_i = 1'b0;
        @(negedge clk_i);
        check("break_release", 32'({tx_o, tx_ready_o}), 32'b11);
        send(8'h81, 3, 1'b0, 1'b0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
